// File: rtl/des_pkg.sv
// Shared DES definitions: controller states, permutation tables, per-round key
// rotation amounts and the bit-permutation helpers built on them.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } des_state_e;

  // Table entries use DES numbering: bit 1 is the MSB of the source vector.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  // Decrypt starts from the unrotated C/D so that round 0 uses K16.
  localparam int ENC_ROT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int DEC_ROT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
    return y;
  endfunction

  function automatic logic [55:0] rotate_cd(input logic [55:0] cd, input logic decrypt,
                                            input logic [3:0] rnd);
    logic [27:0] c, d;
    int amt;
    c = cd[55:28];
    d = cd[27:0];
    amt = decrypt ? DEC_ROT[rnd] : ENC_ROT[rnd];
    if (decrypt) begin
      if (amt == 1) begin
        c = {c[0], c[27:1]};
        d = {d[0], d[27:1]};
      end else if (amt == 2) begin
        c = {c[1:0], c[27:2]};
        d = {d[1:0], d[27:2]};
      end
    end else begin
      if (amt == 1) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else if (amt == 2) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
    end
    return {c, d};
  endfunction

endpackage

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: holds the C/D halves, rotates them once per round
// and presents PC2 of the rotated value as the current round subkey.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] key,
  input  logic        advance,
  input  logic        decrypt,
  input  logic [3:0]  round_cnt,
  output logic [47:0] subkey
);

  logic [55:0] cd_q, cd_d, cd_rot;

  always_comb begin
    cd_rot = rotate_cd(cd_q, decrypt, round_cnt);
    cd_d   = cd_q;
    if (load) begin
      cd_d = des_pc1(key);
    end else if (advance) begin
      cd_d = cd_rot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q <= '0;
    end else begin
      cd_q <= cd_d;
    end
  end

  assign subkey = des_pc2(cd_rot);

endmodule

// File: rtl/des_iter_controller.sv
// Iterative DES controller: accepts a block, steps an external round unit through
// 16 rounds and holds the permuted result until the consumer takes it.
module des_iter_controller
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic [31:0] rnd_left,
  output logic [31:0] rnd_right,
  output logic [47:0] rnd_subkey,
  input  logic [31:0] rnd_left_next,
  input  logic [31:0] rnd_right_next,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy,
  output logic [3:0]  round_cnt
);

  des_state_e  state_q, state_d;
  logic [31:0] left_q, left_d, right_q, right_d;
  logic [3:0]  round_cnt_q, round_cnt_d;
  logic        decrypt_q, decrypt_d;
  logic [63:0] out_block_q, out_block_d;
  logic        key_load, key_advance;

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    round_cnt_d = round_cnt_q;
    decrypt_d   = decrypt_q;
    out_block_d = out_block_q;
    key_load    = 1'b0;
    key_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          key_load          = 1'b1;
          {left_d, right_d} = des_ip(in_block);
          decrypt_d         = in_decrypt;
          round_cnt_d       = 4'd0;
          state_d           = ST_ROUND;
        end
      end
      ST_ROUND: begin
        key_advance = 1'b1;
        left_d      = rnd_left_next;
        right_d     = rnd_right_next;
        // The halves are swapped back before the final permutation.
        if (round_cnt_q == 4'd15) begin
          out_block_d = des_fp({rnd_right_next, rnd_left_next});
          state_d     = ST_DONE;
        end else begin
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          round_cnt_d = 4'd0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      left_q      <= '0;
      right_q     <= '0;
      round_cnt_q <= '0;
      decrypt_q   <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      round_cnt_q <= round_cnt_d;
      decrypt_q   <= decrypt_d;
      out_block_q <= out_block_d;
    end
  end

  des_key_schedule u_key_schedule (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (key_load),
    .key       (in_key),
    .advance   (key_advance),
    .decrypt   (decrypt_q),
    .round_cnt (round_cnt_q),
    .subkey    (rnd_subkey)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_block = out_block_q;
  assign rnd_left  = left_q;
  assign rnd_right = right_q;
  assign round_cnt = round_cnt_q;

endmodule
